ecg_fifo_axis_packetizer: RTL and testbench

Downstream drain stage for the CSR-gated sample FIFO. It pulls 32-bit samples through the FIFO read port and emits them as AXI4-Stream packets of a programmable length, with TLAST on the final beat. Backpressure from the stream sink is absorbed by a 2-entry output buffer. The FIFO's registered one-cycle read latency is accounted for by an in-flight read tracker.

---
 rtl/ecg_stream_pkg.sv | 18 +
 rtl/axis_out_buf2.sv | 47 ++++
 rtl/ecg_fifo_axis_packetizer.sv | 123 ++++++++++++
 tb/tb_ecg_fifo_axis_packetizer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_stream_pkg.sv
// Shared types and constants for the sample-stream packetizer.
package ecg_stream_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    WAIT_LAST = 2'd2
  } state_t;

  // A programmed length of zero still produces single-beat packets.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/axis_out_buf2.sv
// Two-entry skid buffer holding {last, data} beats between the FIFO read port and the stream.
module axis_out_buf2
  import ecg_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_DATA_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign occ  = occ_q;

endmodule

// File: rtl/ecg_fifo_axis_packetizer.sv
// Drains the sample FIFO into fixed-length AXI4-Stream packets with TLAST on the final beat.
module ecg_fifo_axis_packetizer
  import ecg_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  busy,
  output logic                  pkt_done,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  localparam int unsigned BUF_W = DATA_WIDTH + 1;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] rd_cnt;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 inflight;
  logic                 inflight_last;
  logic                 start;
  logic                 hs;
  logic                 hs_last;
  logic                 head_last;
  logic [BUF_W-1:0]     head;
  logic [1:0]           occ;
  logic [CNT_WIDTH-1:0] pkt_count_q;

  axis_out_buf2 #(.WIDTH(BUF_W)) u_buf (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (inflight),
    .push_data ({inflight_last, fifo_data_out}),
    .pop       (hs),
    .head      (head),
    .occ       (occ)
  );

  assign M_AXIS_TVALID           = (occ != 2'd0);
  assign {head_last, M_AXIS_TDATA} = head;
  assign M_AXIS_TLAST            = M_AXIS_TVALID & head_last;
  assign hs                      = M_AXIS_TVALID & M_AXIS_TREADY;
  assign hs_last                 = hs & head_last;
  assign pkt_done                = hs_last;
  assign busy                    = (state != IDLE);
  assign pkt_count               = pkt_count_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Reads only while a buffer slot is guaranteed for the word coming back next cycle.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          start     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        fifo_rd_en = !fifo_empty && (rd_cnt < len_q) &&
                     ((3'(occ) + 3'(inflight)) < 3'd2);
        if (fifo_rd_en && (LEN_WIDTH'(rd_cnt + LEN_WIDTH'(1)) == len_q)) begin
          state_nxt = WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (hs_last) begin
          if (enable) begin
            start     = 1'b1;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q         <= LEN_WIDTH'(1);
      rd_cnt        <= '0;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      pkt_count_q   <= '0;
    end else begin
      if (start) begin
        len_q  <= LEN_WIDTH'(eff_len(32'(pkt_len)));
        rd_cnt <= '0;
      end else if (fifo_rd_en) begin
        rd_cnt <= rd_cnt + LEN_WIDTH'(1);
      end
      if (start || hs_last)  beat_cnt <= '0;
      else if (hs)           beat_cnt <= beat_cnt + LEN_WIDTH'(1);
      // The word read at index len-1 carries TLAST through the buffer.
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en && (rd_cnt == (len_q - LEN_WIDTH'(1)));
      if (hs_last) pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_ecg_fifo_axis_packetizer.sv
// Directed bench: FIFO read-port model, stream monitor and hand-computed packet expectations.
module tb_ecg_fifo_axis_packetizer;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  pkt_len = 8'd0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_data_out = 32'd0;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic        M_AXIS_TLAST;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_count;

  int n_vec = 0;
  int n_err = 0;

  ecg_fifo_axis_packetizer dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .enable        (enable),
    .pkt_len       (pkt_len),
    .fifo_empty    (fifo_empty),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .busy          (busy),
    .pkt_done      (pkt_done),
    .pkt_count     (pkt_count)
  );

  always #5 ACLK = ~ACLK;

  // FIFO model with registered one-cycle read latency
  logic [31:0] fmem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic        fifo_flush = 1'b0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge ACLK) begin
    if (fifo_flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en) begin
      fifo_data_out <= fmem[rd_ptr];
      rd_ptr        <= rd_ptr + 8'd1;
    end
  end

  // Stream monitor, sampled mid-cycle
  logic [31:0] cap_d [0:255];
  logic        cap_l [0:255];
  int          cap_n = 0;
  int          done_cnt = 0;
  int          stall_err = 0;
  int          rule_err = 0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_beat = 33'd0;

  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !(M_AXIS_TVALID && ({M_AXIS_TLAST, M_AXIS_TDATA} == prev_beat)))
        stall_err <= stall_err + 1;
      prev_stall <= M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_beat  <= {M_AXIS_TLAST, M_AXIS_TDATA};
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        cap_d[cap_n] <= M_AXIS_TDATA;
        cap_l[cap_n] <= M_AXIS_TLAST;
        cap_n        <= cap_n + 1;
      end
      if (pkt_done) done_cnt <= done_cnt + 1;
      if (fifo_rd_en && ((32'(dut.occ) + 32'(dut.inflight)) >= 2)) rule_err <= rule_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    fmem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_cap(input int n, input int budget, input string tag);
    int b = 0;
    while (cap_n < n && b < budget) begin
      tick();
      b++;
    end
    chk({tag, "_timeout"}, 64'(cap_n >= n), 64'd1);
  endtask

  task automatic wait_cap_neg(input int n, input int budget, input string tag);
    int b = 0;
    while (cap_n < n && b < budget) begin
      @(negedge ACLK);
      #1;
      b++;
    end
    chk({tag, "_timeout"}, 64'(cap_n >= n), 64'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int b = 0;
    while (busy && b < budget) begin
      tick();
      b++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_seq(input int base, input int first, input int n, input int plen,
                           input string tag);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_data%0d", tag, k), 64'(cap_d[base + k]), 64'(first + k));
      chk($sformatf("%s_last%0d", tag, k), 64'(cap_l[base + k]), 64'(((k + 1) % plen) == 0));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tvalid"}, 64'(M_AXIS_TVALID), 64'd0);
    chk({tag, "_tlast"},  64'(M_AXIS_TLAST),  64'd0);
    chk({tag, "_tdata"},  64'(M_AXIS_TDATA),  64'd0);
    chk({tag, "_busy"},   64'(busy),          64'd0);
    chk({tag, "_rd_en"},  64'(fifo_rd_en),    64'd0);
    chk({tag, "_done"},   64'(pkt_done),      64'd0);
    chk({tag, "_count"},  64'(pkt_count),     64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int done0;
    int cyc;
    int b;

    // reset state
    #2 ARESET = 1'b1;
    #1 check_zero_outputs("reset");
    tick();
    tick();
    ARESET = 1'b0;
    M_AXIS_TREADY = 1'b1;

    // basic packets of 4 from words 1..10
    base = cap_n;
    done0 = done_cnt;
    for (int i = 1; i <= 10; i++) push_word(32'(i));
    pkt_len = 8'd4;
    enable = 1'b1;
    wait_cap(base + 10, 100, "basic");
    repeat (5) tick();
    check_seq(base, 1, 10, 4, "basic");
    chk("basic_count", 64'(pkt_count), 64'd2);
    chk("basic_pulses", 64'(done_cnt - done0), 64'd2);
    chk("basic_starved_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    enable = 1'b0;
    push_word(32'd11);
    push_word(32'd12);
    wait_cap(base + 12, 50, "basic_tail");
    wait_idle(50, "basic_tail");
    check_seq(base + 10, 11, 2, 2, "basic_tail");
    chk("basic_tail_count", 64'(pkt_count), 64'd3);

    // backpressure: TREADY pattern 1,0,0,1
    base = cap_n;
    done0 = done_cnt;
    for (int i = 0; i < 16; i++) push_word(32'(101 + i));
    pkt_len = 8'd8;
    enable = 1'b1;
    cyc = 0;
    b = 0;
    while ((busy || (cap_n - base) < 16) && b < 300) begin
      M_AXIS_TREADY = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      if ((cap_n - base) >= 9) enable = 1'b0;
      tick();
      cyc++;
      b++;
    end
    M_AXIS_TREADY = 1'b1;
    chk("bp_beats", 64'(cap_n - base), 64'd16);
    check_seq(base, 101, 16, 8, "bp");
    chk("bp_stall_hold", 64'(stall_err), 64'd0);
    chk("bp_issue_rule", 64'(rule_err), 64'd0);
    chk("bp_pulses", 64'(done_cnt - done0), 64'd2);
    chk("bp_count", 64'(pkt_count), 64'd5);

    // disable after beat 2 of a 6-beat packet
    base = cap_n;
    for (int i = 0; i < 10; i++) push_word(32'(201 + i));
    pkt_len = 8'd6;
    enable = 1'b1;
    wait_cap(base + 2, 50, "dis");
    enable = 1'b0;
    wait_idle(50, "dis");
    repeat (3) tick();
    chk("dis_beats", 64'(cap_n - base), 64'd6);
    check_seq(base, 201, 6, 6, "dis");
    chk("dis_fifo_left", 64'(8'(wr_ptr - rd_ptr)), 64'd4);
    chk("dis_count", 64'(pkt_count), 64'd6);
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;

    // underrun: 3 words, then 2 more later
    base = cap_n;
    pkt_len = 8'd5;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push_word(32'(301 + i));
    wait_cap(base + 3, 50, "urun");
    repeat (4) tick();
    chk("urun_tvalid_drop", 64'(M_AXIS_TVALID), 64'd0);
    chk("urun_beats_mid", 64'(cap_n - base), 64'd3);
    chk("urun_busy_mid", 64'(busy), 64'd1);
    repeat (14) tick();
    push_word(32'd304);
    push_word(32'd305);
    enable = 1'b0;
    wait_idle(50, "urun");
    chk("urun_beats", 64'(cap_n - base), 64'd5);
    check_seq(base, 301, 5, 5, "urun");
    chk("urun_count", 64'(pkt_count), 64'd7);

    // zero length means single-beat packets
    base = cap_n;
    done0 = done_cnt;
    pkt_len = 8'd0;
    for (int i = 0; i < 3; i++) push_word(32'(401 + i));
    enable = 1'b1;
    wait_cap_neg(base + 2, 50, "zero");
    tick();
    enable = 1'b0;
    wait_idle(50, "zero");
    chk("zero_beats", 64'(cap_n - base), 64'd3);
    check_seq(base, 401, 3, 1, "zero");
    chk("zero_pulses", 64'(done_cnt - done0), 64'd3);
    chk("zero_count", 64'(pkt_count), 64'd10);

    // packet counter wrap
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    chk("wrap_preload", 64'(pkt_count), 64'hFFFF);
    base = cap_n;
    pkt_len = 8'd1;
    push_word(32'd501);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle(50, "wrap");
    check_seq(base, 501, 1, 1, "wrap");
    chk("wrap_count", 64'(pkt_count), 64'd0);

    // asynchronous reset during beat 2 of a 4-beat packet
    base = cap_n;
    pkt_len = 8'd4;
    for (int i = 0; i < 8; i++) push_word(32'(601 + i));
    enable = 1'b1;
    wait_cap_neg(base + 2, 50, "rst");
    ARESET = 1'b1;
    #1 check_zero_outputs("rst_mid");
    fifo_flush = 1'b1;
    tick();
    fifo_flush = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'(701 + i));
    tick();
    ARESET = 1'b0;
    chk("rst_beat_cnt", 64'(dut.beat_cnt), 64'd0);
    base = cap_n;
    wait_cap(base + 1, 50, "rst_new");
    enable = 1'b0;
    wait_idle(50, "rst_new");
    chk("rst_new_beats", 64'(cap_n - base), 64'd4);
    check_seq(base, 701, 4, 4, "rst_new");
    chk("rst_new_count", 64'(pkt_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
